// File: rtl/noc_bus_arbiter.sv
// ---------------------------------------------------------------------------
// noc_bus_arbiter
//
// Arbitrates the shared 8-bit NoC data bus and the shared ack bus among four
// agents (MEM=0, SHA=1, AES=2, CTRL=3).
//
// Data bus : round-robin tenures, each capped at MAX_BEATS valid&ready beats,
//            followed by a one-cycle turnaround before the next arbitration.
// Ack bus  : independent single-cycle round-robin, can grant every cycle.
//
// Optional feature: define NOC_BUS_ARB_TIMEOUT_EN to revoke a tenure after
// TIMEOUT_CYCLES consecutive cycles without a beat (pulses timeout_err).
// Without the macro timeout_err is tied low.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   bus_req      per-agent data-bus request, held for the whole tenure
//   bus_valid    observed bus valid
//   bus_ready    observed bus ready
//   bus_grant    one-hot drive permission
//   bus_owner    current/last owner ID (bus mux select)
//   bus_busy     high while a grant is active
//   beat_count   beats completed in the current/last tenure
//   stray_beat   pulse: a beat was seen while nobody held the bus
//   ack_req      per-agent ack-bus request
//   ack_dest     destination ID per agent, [2i+1:2i] for agent i
//   ack_grant    one-hot one-cycle ack strobe
//   ack_owner    winning agent ID
//   ack_id       destination ID carried on the ack bus
//   ack_valid    ack bus carries a valid ack
//   timeout_err  pulse on forced revoke (optional feature only)
// ---------------------------------------------------------------------------
module noc_bus_arbiter #(
    parameter int MAX_BEATS      = 36,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bus_req,
    input  logic       bus_valid,
    input  logic       bus_ready,
    output logic [3:0] bus_grant,
    output logic [1:0] bus_owner,
    output logic       bus_busy,
    output logic [8:0] beat_count,
    output logic       stray_beat,
    input  logic [3:0] ack_req,
    input  logic [7:0] ack_dest,
    output logic [3:0] ack_grant,
    output logic [1:0] ack_owner,
    output logic [1:0] ack_id,
    output logic       ack_valid,
    output logic       timeout_err
);

    // Elaboration-time parameter range guard.
    if (MAX_BEATS < 1 || MAX_BEATS > 511 ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1023) begin : g_param_check
        $error("noc_bus_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT      = 2'd1,
        TURNAROUND = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic [3:0] bus_grant_nx;
    logic [1:0] bus_owner_nx;
    logic       bus_busy_nx;
    logic [8:0] beat_count_nx;
    logic       stray_beat_nx;
    logic [1:0] last_owner, last_owner_nx;
    logic [1:0] bus_win;
    logic       beat;
    logic [8:0] beat_inc;
    logic       cap_hit;
    logic       expire;

    logic [3:0] ack_grant_nx;
    logic [1:0] ack_owner_nx;
    logic [1:0] ack_id_nx;
    logic       ack_valid_nx;
    logic [1:0] ack_ptr, ack_ptr_nx;
    logic [1:0] ack_win;

    // Round-robin pick: search ptr+1, ptr+2, ptr+3, ptr; the last winner
    // (ptr) therefore has the lowest priority.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign beat     = bus_valid & bus_ready;
    assign beat_inc = (beat_count == 9'd511) ? 9'd511 : beat_count + 9'd1;
    assign cap_hit  = beat && (beat_inc == 9'(MAX_BEATS));
    assign bus_win  = rr_pick(bus_req, last_owner);
    assign ack_win  = rr_pick(ack_req, ack_ptr);

`ifdef NOC_BUS_ARB_TIMEOUT_EN
    logic [9:0] idle_cnt, idle_cnt_nx;
    logic       timeout_err_nx;
`endif

    // Data-bus FSM: next state and next registered outputs.
    always_comb begin
        state_nx      = state;
        bus_grant_nx  = bus_grant;
        bus_owner_nx  = bus_owner;
        bus_busy_nx   = bus_busy;
        beat_count_nx = beat_count;
        last_owner_nx = last_owner;
        stray_beat_nx = 1'b0;
        expire        = 1'b0;
`ifdef NOC_BUS_ARB_TIMEOUT_EN
        idle_cnt_nx    = idle_cnt;
        timeout_err_nx = 1'b0;
`endif
        case (state)
            IDLE: begin
                stray_beat_nx = beat;
                if (|bus_req) begin
                    state_nx      = GRANT;
                    bus_grant_nx  = 4'b0001 << bus_win;
                    bus_owner_nx  = bus_win;
                    bus_busy_nx   = 1'b1;
                    beat_count_nx = 9'd0;
                    last_owner_nx = bus_win;
`ifdef NOC_BUS_ARB_TIMEOUT_EN
                    idle_cnt_nx   = 10'd0;
`endif
                end
            end
            GRANT: begin
                if (beat) begin
                    beat_count_nx = beat_inc;
                end
`ifdef NOC_BUS_ARB_TIMEOUT_EN
                // A beat in the would-be expiry cycle keeps the tenure alive.
                if (beat) begin
                    idle_cnt_nx = 10'd0;
                end else if (idle_cnt == 10'(TIMEOUT_CYCLES - 1)) begin
                    expire = 1'b1;
                end else begin
                    idle_cnt_nx = idle_cnt + 10'd1;
                end
`endif
                if (!bus_req[bus_owner] || cap_hit || expire) begin
                    state_nx     = TURNAROUND;
                    bus_grant_nx = 4'b0000;
                    bus_busy_nx  = 1'b0;
`ifdef NOC_BUS_ARB_TIMEOUT_EN
                    timeout_err_nx = expire;
`endif
                end
            end
            TURNAROUND: begin
                stray_beat_nx = beat;
                state_nx      = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Ack arbiter: one decision per cycle, owner/id hold while idle.
    always_comb begin
        ack_grant_nx = 4'b0000;
        ack_valid_nx = 1'b0;
        ack_owner_nx = ack_owner;
        ack_id_nx    = ack_id;
        ack_ptr_nx   = ack_ptr;
        if (|ack_req) begin
            ack_grant_nx = 4'b0001 << ack_win;
            ack_valid_nx = 1'b1;
            ack_owner_nx = ack_win;
            ack_id_nx    = ack_dest[{ack_win, 1'b0} +: 2];
            ack_ptr_nx   = ack_win;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bus_grant  <= 4'b0000;
            bus_owner  <= 2'd0;
            bus_busy   <= 1'b0;
            beat_count <= 9'd0;
            stray_beat <= 1'b0;
            last_owner <= 2'd3;
            ack_grant  <= 4'b0000;
            ack_owner  <= 2'd0;
            ack_id     <= 2'd0;
            ack_valid  <= 1'b0;
            ack_ptr    <= 2'd3;
        end else begin
            state      <= state_nx;
            bus_grant  <= bus_grant_nx;
            bus_owner  <= bus_owner_nx;
            bus_busy   <= bus_busy_nx;
            beat_count <= beat_count_nx;
            stray_beat <= stray_beat_nx;
            last_owner <= last_owner_nx;
            ack_grant  <= ack_grant_nx;
            ack_owner  <= ack_owner_nx;
            ack_id     <= ack_id_nx;
            ack_valid  <= ack_valid_nx;
            ack_ptr    <= ack_ptr_nx;
        end
    end

`ifdef NOC_BUS_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt    <= 10'd0;
            timeout_err <= 1'b0;
        end else begin
            idle_cnt    <= idle_cnt_nx;
            timeout_err <= timeout_err_nx;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_noc_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_noc_bus_arbiter
//
// Directed bench for noc_bus_arbiter (default build, MAX_BEATS=36).
// Inputs change 1 time unit after the rising edge; outputs are checked at
// the same point, so each tick() shows the result of one sampled edge.
// ---------------------------------------------------------------------------
module tb_noc_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] bus_req;
    logic       bus_valid;
    logic       bus_ready;
    logic [3:0] bus_grant;
    logic [1:0] bus_owner;
    logic       bus_busy;
    logic [8:0] beat_count;
    logic       stray_beat;
    logic [3:0] ack_req;
    logic [7:0] ack_dest;
    logic [3:0] ack_grant;
    logic [1:0] ack_owner;
    logic [1:0] ack_id;
    logic       ack_valid;
    logic       timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    noc_bus_arbiter #(
        .MAX_BEATS     (36),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_req    (bus_req),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_grant  (bus_grant),
        .bus_owner  (bus_owner),
        .bus_busy   (bus_busy),
        .beat_count (beat_count),
        .stray_beat (stray_beat),
        .ack_req    (ack_req),
        .ack_dest   (ack_dest),
        .ack_grant  (ack_grant),
        .ack_owner  (ack_owner),
        .ack_id     (ack_id),
        .ack_valid  (ack_valid),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bus_req   = 4'b0000;
        bus_valid = 1'b0;
        bus_ready = 1'b0;
        ack_req   = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int exp_w;
        rst       = 1'b1;
        bus_req   = 4'b0000;
        bus_valid = 1'b0;
        bus_ready = 1'b0;
        ack_req   = 4'b0000;
        ack_dest  = 8'b00_10_01_11; // CTRL=0, AES=2, SHA=1, MEM=3

        // Reset state
        do_reset();
        check_eq("rst_grant", 32'(bus_grant), 32'h0);
        check_eq("rst_owner", 32'(bus_owner), 32'h0);
        check_eq("rst_busy", 32'(bus_busy), 32'h0);
        check_eq("rst_beats", 32'(beat_count), 32'h0);
        check_eq("rst_stray", 32'(stray_beat), 32'h0);
        check_eq("rst_ackv", 32'(ack_valid), 32'h0);
        check_eq("rst_ackg", 32'(ack_grant), 32'h0);
        check_eq("rst_tmo", 32'(timeout_err), 32'h0);

        // SHA wins over AES from reset pointer 3; drop -> AES 3 cycles later
        bus_req = 4'b0110;
        tick();
        check_eq("s1_grant", 32'(bus_grant), 32'h2);
        check_eq("s1_owner", 32'(bus_owner), 32'h1);
        check_eq("s1_busy", 32'(bus_busy), 32'h1);
        bus_req = 4'b0100;
        tick();
        check_eq("s1_ta_grant", 32'(bus_grant), 32'h0);
        check_eq("s1_ta_busy", 32'(bus_busy), 32'h0);
        check_eq("s1_ta_owner", 32'(bus_owner), 32'h1);
        tick();
        check_eq("s1_idle_grant", 32'(bus_grant), 32'h0);
        tick();
        check_eq("s1_aes_grant", 32'(bus_grant), 32'h4);
        check_eq("s1_aes_owner", 32'(bus_owner), 32'h2);
        bus_req = 4'b0000;
        tick();
        tick();

        // All request; each owner does 3 beats then drops and re-requests
        do_reset();
        bus_req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            exp_w = k % 4;
            check_eq("rr_grant", 32'(bus_grant), 32'(1 << exp_w));
            check_eq("rr_owner", 32'(bus_owner), 32'(exp_w));
            bus_valid = 1'b1;
            bus_ready = 1'b1;
            for (int b = 1; b <= 3; b++) begin
                tick();
                check_eq("rr_beats", 32'(beat_count), 32'(b));
            end
            bus_valid = 1'b0;
            bus_ready = 1'b0;
            bus_req[exp_w] = 1'b0;
            tick();
            check_eq("rr_exit_grant", 32'(bus_grant), 32'h0);
            check_eq("rr_exit_beats", 32'(beat_count), 32'h3);
            bus_req[exp_w] = 1'b1;
            tick();
            tick();
        end
        bus_req = 4'b0000;
        tick();
        tick();

        // SHA alone streams 40 beats: cap at 36, gap of 2, then regrant
        do_reset();
        bus_req = 4'b0010;
        tick();
        check_eq("cap_grant0", 32'(bus_grant), 32'h2);
        bus_valid = 1'b1;
        bus_ready = 1'b1;
        for (int b = 1; b <= 35; b++) tick();
        check_eq("cap_b35_grant", 32'(bus_grant), 32'h2);
        check_eq("cap_b35_beats", 32'(beat_count), 32'd35);
        tick();
        check_eq("cap_b36_grant", 32'(bus_grant), 32'h0);
        check_eq("cap_b36_busy", 32'(bus_busy), 32'h0);
        check_eq("cap_b36_beats", 32'(beat_count), 32'd36);
        check_eq("cap_b36_stray", 32'(stray_beat), 32'h0);
        tick();
        check_eq("cap_b37_grant", 32'(bus_grant), 32'h0);
        check_eq("cap_b37_stray", 32'(stray_beat), 32'h1);
        check_eq("cap_b37_beats", 32'(beat_count), 32'd36);
        tick();
        check_eq("cap_regrant", 32'(bus_grant), 32'h2);
        check_eq("cap_regrant_beats", 32'(beat_count), 32'd0);
        tick();
        tick();
        check_eq("cap_b40_beats", 32'(beat_count), 32'd2);
        bus_valid = 1'b0;
        bus_ready = 1'b0;
        bus_req   = 4'b0000;
        tick();
        tick();

        // Stray beat in IDLE
        bus_valid = 1'b1;
        bus_ready = 1'b1;
        tick();
        check_eq("stray_pulse", 32'(stray_beat), 32'h1);
        check_eq("stray_beats", 32'(beat_count), 32'd2);
        check_eq("stray_nogrant", 32'(bus_grant), 32'h0);
        bus_valid = 1'b0;
        bus_ready = 1'b0;
        tick();
        check_eq("stray_clear", 32'(stray_beat), 32'h0);

        // Ack bus: MEM and CTRL alternate every cycle
        do_reset();
        ack_req = 4'b1001;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_eq("ack_valid", 32'(ack_valid), 32'h1);
            check_eq("ack_grant", 32'(ack_grant), (k % 2 == 0) ? 32'h1 : 32'h8);
            check_eq("ack_owner", 32'(ack_owner), (k % 2 == 0) ? 32'h0 : 32'h3);
            check_eq("ack_id", 32'(ack_id), (k % 2 == 0) ? 32'h3 : 32'h0);
        end
        ack_req = 4'b0000;
        tick();
        check_eq("ack_idle_valid", 32'(ack_valid), 32'h0);
        check_eq("ack_idle_grant", 32'(ack_grant), 32'h0);
        check_eq("ack_idle_owner", 32'(ack_owner), 32'h3);
        check_eq("ack_idle_id", 32'(ack_id), 32'h0);
        ack_req = 4'b0100;
        tick();
        check_eq("ack_aes_grant", 32'(ack_grant), 32'h4);
        check_eq("ack_aes_id", 32'(ack_id), 32'h2);
        ack_req = 4'b0000;
        tick();

        // Reset mid-tenure: grant drops next cycle, no timeout in default build
        bus_req = 4'b0001;
        tick();
        check_eq("mid_grant", 32'(bus_grant), 32'h1);
        for (int k = 0; k < 70; k++) tick();
        check_eq("no_timeout_grant", 32'(bus_grant), 32'h1);
        check_eq("no_timeout_err", 32'(timeout_err), 32'h0);
        rst = 1'b1;
        tick();
        check_eq("mid_rst_grant", 32'(bus_grant), 32'h0);
        check_eq("mid_rst_busy", 32'(bus_busy), 32'h0);
        check_eq("mid_rst_owner", 32'(bus_owner), 32'h0);
        check_eq("mid_rst_beats", 32'(beat_count), 32'h0);
        rst = 1'b0;
        bus_req = 4'b0000;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
